// File: rtl/mem_pkg.sv
// Shared definitions for the MEM-stage data RAM controller: operation codes,
// controller states, RAM byte-select encodings and small decode helpers.
package mem_pkg;

  typedef enum logic [2:0] {
    OP_LB  = 3'd0,
    OP_LBU = 3'd1,
    OP_LH  = 3'd2,
    OP_LHU = 3'd3,
    OP_LW  = 3'd4,
    OP_SB  = 3'd5,
    OP_SH  = 3'd6,
    OP_SW  = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR0  = 3'd2,
    ST_WR1  = 3'd3,
    ST_RESP = 3'd4
  } state_t;

  localparam logic [3:0] SEL_WORD = 4'b0001;
  localparam logic [3:0] SEL_BYTE = 4'b0000;

  // Number of bytes an operation touches.
  function automatic logic [2:0] op_size(input op_t op);
    case (op)
      OP_LH, OP_LHU, OP_SH: op_size = 3'd2;
      OP_LW, OP_SW:         op_size = 3'd4;
      default:              op_size = 3'd1;
    endcase
  endfunction

  function automatic logic is_load(input op_t op);
    is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
              (op == OP_LHU) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load result formatting: picks the big-endian leading byte/halfword of the
// RAM read word and sign- or zero-extends it to 32 bits.
module load_extend
  import mem_pkg::*;
(
  input  op_t         op,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  // Extend according to the load flavour; stores produce zero.
  always_comb begin
    // NOTE: default assignment first so every path drives result (no latch).
    result = '0;
    case (op)
      OP_LB:   result = {{24{rdata[31]}}, rdata[31:24]};
      OP_LBU:  result = {24'b0, rdata[31:24]};
      OP_LH:   result = {{16{rdata[31]}}, rdata[31:16]};
      OP_LHU:  result = {16'b0, rdata[31:16]};
      OP_LW:   result = rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_access.sv
// MEM-stage initiator for the big-endian byte-addressed data RAM. Accepts one
// load/store at a time, checks alignment and range at capture, sequences the
// RAM bus (halfword stores become two byte writes) and returns a one-cycle
// response pulse. RAM outputs depend only on registered state.
module data_mem_access
  import mem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        ram_ce,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  input  logic [31:0] ram_rdata
);

  state_t      state, state_next;
  op_t         op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] ext_data;

  op_t         req_op_t;
  logic        handshake;
  logic        misaligned;
  logic        out_of_range;
  logic        req_err;
  logic [32:0] end_addr;

  assign req_op_t  = op_t'(req_op);
  assign req_ready = (state == ST_IDLE) && rst;
  assign handshake = req_valid && req_ready;

  // Alignment and range check on the incoming request (33-bit sum cannot wrap).
  always_comb begin
    misaligned = 1'b0;
    case (req_op_t)
      OP_LH, OP_LHU, OP_SH: misaligned = req_addr[0];
      OP_LW, OP_SW:         misaligned = |req_addr[1:0];
      default:              misaligned = 1'b0;
    endcase
  end

  assign end_addr     = {1'b0, req_addr} + {30'b0, op_size(req_op_t)};
  assign out_of_range = end_addr > 33'(MEM_BYTES);
  assign req_err      = misaligned || out_of_range;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst) state <= ST_IDLE;
    else      state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (handshake) begin
          if (req_err)                state_next = ST_RESP;
          else if (is_load(req_op_t)) state_next = ST_RD;
          else                        state_next = ST_WR0;
        end
      end
      ST_RD:   state_next = ST_RESP;
      ST_WR0:  state_next = (op_q == OP_SH) ? ST_WR1 : ST_RESP;
      ST_WR1:  state_next = ST_RESP;
      ST_RESP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Capture the request on the handshake edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q    <= OP_LB;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (handshake) begin
      op_q    <= req_op_t;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  load_extend u_load_extend (
    .op     (op_q),
    .rdata  (ram_rdata),
    .result (ext_data)
  );

  // Response registers update only when entering RESP, so they hold between responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (state_next == ST_RESP) begin
      resp_err_q   <= (state == ST_IDLE);
      resp_rdata_q <= (state == ST_RD) ? ext_data : '0;
    end
  end

  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign busy       = (state != ST_IDLE);

  // RAM bus decode from state and the registered request.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_sel   = SEL_BYTE;
    case (state)
      ST_RD: begin
        ram_ce   = 1'b1;
        ram_addr = addr_q;
      end
      ST_WR0: begin
        ram_ce   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = addr_q;
        case (op_q)
          OP_SW: begin
            ram_sel   = SEL_WORD;
            ram_wdata = wdata_q;
          end
          OP_SH:   ram_wdata = {wdata_q[15:8], 24'b0};
          default: ram_wdata = {wdata_q[7:0], 24'b0};
        endcase
      end
      ST_WR1: begin
        ram_ce    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = addr_q + 32'd1;
        ram_wdata = {wdata_q[7:0], 24'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_data_mem_access.sv
// Directed bench for data_mem_access: a byte-array RAM model, a table of
// load/store vectors with hand-computed results, and hand sequences for the
// halfword split, reset behaviour and mid-store reset.
module tb_data_mem_access;
  import mem_pkg::*;

  localparam int MEM = 1001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_sel;
  logic [31:0] ram_rdata;

  int total = 0;
  int bad   = 0;

  data_mem_access #(.MEM_BYTES(MEM)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .busy       (busy),
    .ram_ce     (ram_ce),
    .ram_we     (ram_we),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_sel    (ram_sel),
    .ram_rdata  (ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: big-endian byte array, combinational read, write on clock edge.
  logic [7:0]  mem [MEM];
  logic [31:0] wl_addr [$];
  logic [7:0]  wl_byte [$];
  logic [3:0]  wl_sel  [$];
  int          ce_total = 0;

  initial for (int i = 0; i < MEM; i++) mem[i] = 8'h00;

  always_comb begin
    ram_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (ram_addr < 32'(MEM - i))
        ram_rdata[31 - 8*i -: 8] = mem[int'(ram_addr) + i];
    end
  end

  always @(posedge clk) begin
    if (ram_ce) ce_total <= ce_total + 1;
    if (ram_ce && ram_we) begin
      wl_addr.push_back(ram_addr);
      wl_byte.push_back(ram_wdata[31:24]);
      wl_sel.push_back(ram_sel);
      if (ram_sel == SEL_WORD) begin
        for (int i = 0; i < 4; i++)
          if (ram_addr < 32'(MEM - i)) mem[int'(ram_addr) + i] <= ram_wdata[31 - 8*i -: 8];
      end else if (ram_addr < 32'(MEM)) begin
        mem[int'(ram_addr)] <= ram_wdata[31:24];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one request and follow it to its response (bounded).
  task automatic run_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic err, output int lat, output int ce);
    bit done;
    rdata = '0; err = 1'b0; lat = 0; ce = 0; done = 0;
    wl_addr.delete(); wl_byte.delete(); wl_sel.delete();
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 8 && !done; k++) begin
      @(negedge clk);
      if (ram_ce) ce++;
      if (resp_valid) begin
        lat = k; rdata = resp_rdata; err = resp_err; done = 1;
      end
    end
    if (!done) check("response_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    op_t         op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_ce;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, ce;

    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat, ce;

    vecs[0]  = '{OP_SW,  32'h10,  32'h11223344, 32'h11223344 & 32'h0, 1'b0, 2, 1};
    vecs[1]  = '{OP_LW,  32'h10,  32'h0,        32'h11223344, 1'b0, 2, 1};
    vecs[2]  = '{OP_SW,  32'h10,  32'h80FF1234, 32'h0,        1'b0, 2, 1};
    vecs[3]  = '{OP_LB,  32'h10,  32'h0,        32'hFFFFFF80, 1'b0, 2, 1};
    vecs[4]  = '{OP_LBU, 32'h10,  32'h0,        32'h00000080, 1'b0, 2, 1};
    vecs[5]  = '{OP_LH,  32'h10,  32'h0,        32'hFFFF80FF, 1'b0, 2, 1};
    vecs[6]  = '{OP_LHU, 32'h10,  32'h0,        32'h000080FF, 1'b0, 2, 1};
    vecs[7]  = '{OP_LW,  32'h13,  32'h0,        32'h0,        1'b1, 1, 0};
    vecs[8]  = '{OP_SH,  32'h21,  32'h1234,     32'h0,        1'b1, 1, 0};
    vecs[9]  = '{OP_LW,  32'd1000, 32'h0,       32'h0,        1'b1, 1, 0};
    vecs[10] = '{OP_SB,  32'd1000, 32'h0000005A, 32'h0,       1'b0, 2, 1};
    vecs[11] = '{OP_LBU, 32'd1000, 32'h0,       32'h0000005A, 1'b0, 2, 1};
    vecs[12] = '{OP_SW,  32'd996, 32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vecs[13] = '{OP_LW,  32'd996, 32'h0,        32'hDEADBEEF, 1'b0, 2, 1};
    vecs[14] = '{OP_LH,  32'd1000, 32'h0,       32'h0,        1'b1, 1, 0};
    vecs[15] = '{OP_SB,  32'h11,  32'hFFFFFFEE, 32'h0,        1'b0, 2, 1};
    vecs[16] = '{OP_LW,  32'h10,  32'h0,        32'h80EE1234, 1'b0, 2, 1};

    // Reset held: all outputs quiet.
    repeat (3) @(negedge clk);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_ram_ce", 32'(ram_ce), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_req_ready", 32'(req_ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_resp", {resp_rdata[30:0], resp_err}, 32'd0);
      check("idle_ram_bus", ram_addr | ram_wdata | {26'b0, ram_sel, ram_we, ram_ce}, 32'd0);
    end
    check("idle_no_ce_pulse", 32'(ce_total), 32'd0);

    // Table-driven vectors.
    for (int i = 0; i < NV; i++) begin
      run_req(vecs[i].op, vecs[i].addr, vecs[i].wdata, rd, er, lat, ce);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_ce_cycles", i), 32'(ce), 32'(vecs[i].exp_ce));
    end

    // SW word write uses the word select.
    run_req(OP_SW, 32'h30, 32'hCAFEF00D, rd, er, lat, ce);
    check("sw_write_count", 32'(wl_addr.size()), 32'd1);
    if (wl_addr.size() == 1) check("sw_sel", 32'(wl_sel[0]), 32'(SEL_WORD));

    // SH splits into two byte writes.
    run_req(OP_SH, 32'h20, 32'h0000ABCD, rd, er, lat, ce);
    check("sh_latency", 32'(lat), 32'd3);
    check("sh_write_count", 32'(wl_addr.size()), 32'd2);
    if (wl_addr.size() == 2) begin
      check("sh_w0_addr", wl_addr[0], 32'h20);
      check("sh_w0_byte", 32'(wl_byte[0]), 32'hAB);
      check("sh_w0_sel",  32'(wl_sel[0]), 32'(SEL_BYTE));
      check("sh_w1_addr", wl_addr[1], 32'h21);
      check("sh_w1_byte", 32'(wl_byte[1]), 32'hCD);
      check("sh_w1_sel",  32'(wl_sel[1]), 32'(SEL_BYTE));
    end
    run_req(OP_LHU, 32'h20, 32'h0, rd, er, lat, ce);
    check("lhu_after_sh", rd, 32'h0000ABCD);
    @(negedge clk);
    check("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
    check("resp_rdata_held", resp_rdata, 32'h0000ABCD);

    // Reset during WR1 of an SH.
    wl_addr.delete(); wl_byte.delete(); wl_sel.delete();
    @(negedge clk);
    req_op = OP_SH; req_addr = 32'h40; req_wdata = 32'h0000C3D4; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("wr1_reached_addr", ram_addr, 32'h41);
    check("wr1_reached_ce", 32'(ram_ce), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_ce_drop", 32'(ram_ce), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    check("midrst_one_write", 32'(wl_addr.size()), 32'd1);
    run_req(OP_LW, 32'h40, 32'h0, rd, er, lat, ce);
    check("midrst_lw_rdata", rd, 32'hC3000000);
    check("midrst_lw_latency", 32'(lat), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
